if_id_seg_buf: RTL

Parametrised IF/ID segment register that replaces the fixed bubble/flush PC register with a valid/ready pipeline stage. It carries the fetch PC and branch-prediction metadata from IF to ID. A 2-entry (main + skid) buffer keeps the upstream ready registered, so IF never sees a combinational path from ID stall logic. It also exports saturating stall and flush counters for the performance monitor.

---
 rtl/if_id_seg_buf.sv | 114 +++++++++++
 1 files changed

// File: rtl/if_id_seg_buf.sv
// IF/ID segment register: valid/ready pipeline stage with a main + skid slot,
// a registered upstream ready, and saturating stall/flush performance counters.
module if_id_seg_buf #(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned META_W = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flushD,
   input  logic [PC_W-1:0]   PC_IF,
   input  logic [META_W-1:0] PredictF,
   input  logic              valid_IF,
   output logic              ready_IF,
   output logic [PC_W-1:0]   PC_ID,
   output logic [META_W-1:0] PredictD,
   output logic              valid_ID,
   input  logic              ready_ID,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic              vm, vs, rdy_q;
   logic [PC_W-1:0]   pcm, pcs;
   logic [META_W-1:0] mm, ms;

   logic              vm_n, vs_n;
   logic [PC_W-1:0]   pcm_n, pcs_n;
   logic [META_W-1:0] mm_n, ms_n;

   logic acc, drn;
   logic stall_ev, flush_ev;

   assign acc      = valid_IF & rdy_q;
   assign drn      = vm & ready_ID;
   assign stall_ev = vm & ~ready_ID & ~flushD;
   assign flush_ev = flushD & (vm | vs);

   always_comb begin
      vm_n  = vm;
      vs_n  = vs;
      pcm_n = pcm;
      mm_n  = mm;
      pcs_n = pcs;
      ms_n  = ms;
      if (flushD) begin
         vm_n  = 1'b0;
         vs_n  = 1'b0;
         pcm_n = '0;
         mm_n  = '0;
         pcs_n = '0;
         ms_n  = '0;
      end else if (vs && (drn || !vm)) begin
         // ready_IF is low whenever vs is set, so no input can arrive here
         vm_n  = 1'b1;
         pcm_n = pcs;
         mm_n  = ms;
         vs_n  = 1'b0;
         pcs_n = '0;
         ms_n  = '0;
      end else if (vm && !drn && acc) begin
         vs_n  = 1'b1;
         pcs_n = PC_IF;
         ms_n  = PredictF;
      end else if ((drn || !vm) && acc) begin
         vm_n  = 1'b1;
         pcm_n = PC_IF;
         mm_n  = PredictF;
      end else if (drn) begin
         vm_n  = 1'b0;
         pcm_n = '0;
         mm_n  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vm    <= 1'b0;
         vs    <= 1'b0;
         pcm   <= '0;
         mm    <= '0;
         pcs   <= '0;
         ms    <= '0;
         rdy_q <= 1'b1;
      end else begin
         vm    <= vm_n;
         vs    <= vs_n;
         pcm   <= pcm_n;
         mm    <= mm_n;
         pcs   <= pcs_n;
         ms    <= ms_n;
         // ready is a flop copy of the next skid state: no path from ready_ID
         rdy_q <= ~vs_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_ev && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_ev && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign ready_IF = rdy_q;
   assign valid_ID = vm;
   assign PC_ID    = pcm;
   assign PredictD = mm;

endmodule
